// File: rtl/qinj_scan_controller.sv
// Charge-injection scan controller: walks a pixel range, holding QInjEn on each pixel
// and issuing a train of QInj pulses. Define QINJ_SCAN_BROADCAST_EN for all-pixel mode.
module qinj_scan_controller #(
    parameter int unsigned SETTLE = 4
) (
    input  logic         CLK40,
    input  logic         RST,
    input  logic         start,
    input  logic         abort,
    input  logic [7:0]   startPix,
    input  logic [7:0]   stopPix,
    input  logic [7:0]   nPulses,
    input  logic [7:0]   gap,
`ifdef QINJ_SCAN_BROADCAST_EN
    input  logic         broadcast,
`endif
    output logic [255:0] QInjEn,
    output logic         QInj,
    output logic         busy,
    output logic         done,
    output logic [7:0]   curPix
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t       r_state;
    logic [7:0]   r_cnt;
    logic [7:0]   r_pulses;
    logic [7:0]   r_stop_pix;
    logic [7:0]   r_npulses;
    logic [7:0]   r_gap;
    logic [255:0] r_qinjen;
    logic         r_qinj;
    logic         r_busy;
    logic         r_done;
    logic [7:0]   r_cur_pix;
    logic         w_bcast_in;
    logic         w_bcast;
    logic         w_accept;

    function automatic logic [255:0] f_enables(input logic [7:0] pix, input logic bc);
        if (bc) begin
            return {256{1'b1}};
        end else begin
            return 256'd1 << pix;
        end
    endfunction

    assign w_accept = start && !abort;

`ifdef QINJ_SCAN_BROADCAST_EN
    logic r_bcast;
    assign w_bcast_in = broadcast;
    assign w_bcast    = r_bcast;

    // Latch the broadcast selection together with the rest of the scan config.
    always_ff @(posedge CLK40) begin
        if (RST) begin
            r_bcast <= 1'b0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_bcast <= broadcast;
        end else begin
            r_bcast <= r_bcast;
        end
    end
`else
    assign w_bcast_in = 1'b0;
    assign w_bcast    = 1'b0;
`endif

    // Scan sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge CLK40) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_pulses   <= 8'd0;
            r_stop_pix <= 8'd0;
            r_npulses  <= 8'd0;
            r_gap      <= 8'd0;
            r_qinjen   <= 256'd0;
            r_qinj     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cur_pix  <= 8'd0;
        end else if (r_state != S_IDLE && abort) begin
            r_state  <= S_IDLE;
            r_qinjen <= 256'd0;
            r_qinj   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_qinj <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_stop_pix <= stopPix;
                        r_npulses  <= (nPulses == 8'd0) ? 8'd1 : nPulses;
                        r_gap      <= (gap == 8'd0) ? 8'd1 : gap;
                        r_cur_pix  <= startPix;
                        r_cnt      <= SETTLE_LAST;
                        r_pulses   <= 8'd0;
                        r_qinjen   <= f_enables(startPix, w_bcast_in);
                        r_busy     <= 1'b1;
                        r_state    <= S_SETTLE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        r_state  <= S_PULSE;
                        r_qinj   <= 1'b1;
                        r_pulses <= r_pulses + 8'd1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_PULSE: begin
                    r_state <= S_GAP;
                    r_cnt   <= r_gap - 8'd1;
                end
                S_GAP: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_pulses < r_npulses) begin
                        r_state  <= S_PULSE;
                        r_qinj   <= 1'b1;
                        r_pulses <= r_pulses + 8'd1;
                    end else begin
                        r_state  <= S_NEXT;
                        r_qinjen <= 256'd0;
                    end
                end
                S_NEXT: begin
                    // Broadcast covers every pixel at once, so it never advances.
                    if (r_cur_pix == r_stop_pix || w_bcast) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cur_pix <= r_cur_pix + 8'd1;
                        r_cnt     <= SETTLE_LAST;
                        r_pulses  <= 8'd0;
                        r_qinjen  <= f_enables(r_cur_pix + 8'd1, 1'b0);
                        r_state   <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_qinjen <= 256'd0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign QInjEn = r_qinjen;
    assign QInj   = r_qinj;
    assign busy   = r_busy;
    assign done   = r_done;
    assign curPix = r_cur_pix;

endmodule

// File: tb/tb_qinj_scan_controller.sv
// Bench for qinj_scan_controller: a trace-generating reference model checked every cycle,
// plus directed scenarios with hand-derived cycle expectations.
module tb_qinj_scan_controller;

    localparam int SETTLE = 4;

    logic         CLK40 = 1'b0;
    logic         RST;
    logic         start;
    logic         abort;
    logic [7:0]   startPix;
    logic [7:0]   stopPix;
    logic [7:0]   nPulses;
    logic [7:0]   gap;
    logic         broadcast;
    logic [255:0] QInjEn;
    logic         QInj;
    logic         busy;
    logic         done;
    logic [7:0]   curPix;

    int checks = 0;
    int errors = 0;

    qinj_scan_controller #(.SETTLE(SETTLE)) dut (
        .CLK40    (CLK40),
        .RST      (RST),
        .start    (start),
        .abort    (abort),
        .startPix (startPix),
        .stopPix  (stopPix),
        .nPulses  (nPulses),
        .gap      (gap),
`ifdef QINJ_SCAN_BROADCAST_EN
        .broadcast(broadcast),
`endif
        .QInjEn   (QInjEn),
        .QInj     (QInj),
        .busy     (busy),
        .done     (done),
        .curPix   (curPix)
    );

    always #5 CLK40 = ~CLK40;

    // ---------------- reference model: expected per-cycle output trace ----------------
    typedef struct {
        logic       busy;
        logic       qinj;
        logic       done;
        logic       en_on;
        logic       en_all;
        logic [7:0] cur;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    bit   model_valid = 1'b0;

    function automatic exp_t mk(input logic b, input logic q, input logic d,
                                input logic on, input logic all, input logic [7:0] c);
        exp_t e;
        e.busy = b; e.qinj = q; e.done = d; e.en_on = on; e.en_all = all; e.cur = c;
        return e;
    endfunction

    function automatic logic [255:0] exp_en(input exp_t e);
        logic [255:0] v;
        v = '0;
        if (e.en_on) begin
            if (e.en_all) v = '1;
            else v[e.cur] = 1'b1;
        end
        return v;
    endfunction

    task automatic build_scan(input logic [7:0] sp, input logic [7:0] ep, input logic [7:0] np,
                              input logic [7:0] gp, input logic bc);
        int npe;
        int gpe;
        logic [7:0] pix;
        logic [7:0] lastpix;
        bit last;
        npe = (np == 8'd0) ? 1 : int'(np);
        gpe = (gp == 8'd0) ? 1 : int'(gp);
        pix = sp;
        lastpix = sp;
        last = 1'b0;
        while (!last) begin
            for (int i = 0; i < SETTLE; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, bc, pix));
            for (int p = 0; p < npe; p++) begin
                exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, bc, pix));
                for (int g = 0; g < gpe; g++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, bc, pix));
            end
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pix));
            last = bc || (pix == ep);
            lastpix = pix;
            pix = pix + 8'd1;
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, lastpix));
    endtask

    always @(posedge CLK40) begin
        if (RST) begin
            exp_q.delete();
            exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            model_valid = 1'b1;
        end else if (exp_cur.busy && abort) begin
            exp_q.delete();
            exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_cur.cur);
        end else if (!exp_cur.busy) begin
            if (start && !abort) begin
                build_scan(startPix, stopPix, nPulses, gap, broadcast);
                exp_cur = exp_q.pop_front();
            end
        end else if (exp_q.size() > 0) begin
            exp_cur = exp_q.pop_front();
        end else begin
            exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_cur.cur);
        end
    end

    always @(negedge CLK40) begin
        if (model_valid) begin
            checks++;
            if (busy !== exp_cur.busy || QInj !== exp_cur.qinj || done !== exp_cur.done ||
                curPix !== exp_cur.cur || QInjEn !== exp_en(exp_cur)) begin
                errors++;
                $display("FAIL model t=%0t: got busy=%b qinj=%b done=%b cur=%0d en=%h, expected busy=%b qinj=%b done=%b cur=%0d en=%h",
                         $time, busy, QInj, done, curPix, QInjEn,
                         exp_cur.busy, exp_cur.qinj, exp_cur.done, exp_cur.cur, exp_en(exp_cur));
            end
        end
    end

    // ---------------- directed scenarios with literal expectations ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic run_basic(input logic [7:0] pix);
        startPix = pix; stopPix = pix; nPulses = 8'd2; gap = 8'd3; start = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge CLK40);
            start = (cyc < 13);
            chk($sformatf("basic_qinj_c%0d", cyc), 256'(QInj), 256'(cyc == 5 || cyc == 9));
            chk($sformatf("basic_en_c%0d", cyc), 256'(QInjEn[pix]), 256'(cyc >= 1 && cyc <= 12));
            chk($sformatf("basic_done_c%0d", cyc), 256'(done), 256'(cyc == 14));
            chk($sformatf("basic_busy_c%0d", cyc), 256'(busy), 256'(cyc >= 1 && cyc <= 14));
        end
        start = 1'b0;
    endtask

    task automatic run_abort();
        startPix = 8'd7; stopPix = 8'd7; nPulses = 8'd2; gap = 8'd3; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge CLK40);
            start = 1'b0;
            abort = (cyc == 7);
            if (cyc >= 8) begin
                chk($sformatf("abort_busy_c%0d", cyc), 256'(busy), 256'd0);
                chk($sformatf("abort_en_c%0d", cyc), QInjEn, 256'd0);
                chk($sformatf("abort_done_c%0d", cyc), 256'(done), 256'd0);
            end
        end
        abort = 1'b0;
    endtask

    task automatic run_reset_mid();
        startPix = 8'd20; stopPix = 8'd22; nPulses = 8'd1; gap = 8'd1; start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge CLK40);
            start = 1'b0;
            if (cyc == 5) chk("rst_pulse_seen", 256'(QInj), 256'd1);
            if (cyc == 6 || cyc == 7) begin
                chk($sformatf("rst_en_c%0d", cyc), QInjEn, 256'd0);
                chk($sformatf("rst_qinj_c%0d", cyc), 256'(QInj), 256'd0);
                chk($sformatf("rst_busy_c%0d", cyc), 256'(busy), 256'd0);
                chk($sformatf("rst_cur_c%0d", cyc), 256'(curPix), 256'd0);
            end
            if (cyc == 9) chk("rst_start_ignored", 256'(busy), 256'd0);
            RST = (cyc == 5 || cyc == 6);
            start = (cyc == 6);
        end
        RST = 1'b0; start = 1'b0;
    endtask

    task automatic run_min();
        startPix = 8'd40; stopPix = 8'd40; nPulses = 8'd0; gap = 8'd0; start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge CLK40);
            start = 1'b0;
            chk($sformatf("min_qinj_c%0d", cyc), 256'(QInj), 256'(cyc == 5));
            chk($sformatf("min_done_c%0d", cyc), 256'(done), 256'(cyc == 8));
        end
    endtask

    task automatic run_count(input logic [7:0] sp, input logic [7:0] ep, input logic [7:0] np,
                             input logic bc, output int pulses, output int dones,
                             output logic [7:0] plog[$], output logic all_seen);
        int n;
        pulses = 0; dones = 0; plog.delete(); all_seen = 1'b0;
        startPix = sp; stopPix = ep; nPulses = np; gap = 8'd1; broadcast = bc; start = 1'b1;
        n = 0;
        do begin
            @(negedge CLK40);
            start = 1'b0;
            if (QInj) begin
                pulses++;
                plog.push_back(curPix);
                if (QInjEn === {256{1'b1}}) all_seen = 1'b1;
            end
            if (done) dones++;
            n++;
        end while (busy && n < 400);
        broadcast = 1'b0;
        if (busy) begin
            checks++; errors++;
            $display("FAIL scan_timeout: got busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    initial begin
        int pulses;
        int dones;
        logic [7:0] plog[$];
        logic all_seen;
        logic [7:0] wrap_exp[4];

        RST = 1'b1; start = 1'b0; abort = 1'b0; broadcast = 1'b0;
        startPix = 8'd0; stopPix = 8'd0; nPulses = 8'd0; gap = 8'd0;
        repeat (3) @(negedge CLK40);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_en", QInjEn, 256'd0);
        chk("reset_qinj", 256'(QInj), 256'd0);
        chk("reset_done", 256'(done), 256'd0);
        chk("reset_cur", 256'(curPix), 256'd0);
        RST = 1'b0;
        @(negedge CLK40);

        run_basic(8'd3);
        run_abort();
        run_basic(8'd9);
        run_reset_mid();
        run_min();

        wrap_exp[0] = 8'd254; wrap_exp[1] = 8'd255; wrap_exp[2] = 8'd0; wrap_exp[3] = 8'd1;
        run_count(8'd254, 8'd1, 8'd1, 1'b0, pulses, dones, plog, all_seen);
        chk("wrap_pulses", 256'(pulses), 256'd4);
        chk("wrap_dones", 256'(dones), 256'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_pix%0d", i), 256'((plog.size() > i) ? plog[i] : 8'hxx), 256'(wrap_exp[i]));
        end

`ifdef QINJ_SCAN_BROADCAST_EN
        run_count(8'd5, 8'd9, 8'd3, 1'b1, pulses, dones, plog, all_seen);
        chk("bcast_pulses", 256'(pulses), 256'd3);
        chk("bcast_dones", 256'(dones), 256'd1);
        chk("bcast_all_ones", 256'(all_seen), 256'd1);
        run_basic(8'd3);
`endif

        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK40);
            start    = ($urandom_range(0, 7) == 0);
            abort    = ($urandom_range(0, 79) == 0);
            RST      = ($urandom_range(0, 299) == 0);
            startPix = 8'($urandom);
            stopPix  = startPix + 8'($urandom_range(0, 3));
            nPulses  = 8'($urandom_range(0, 3));
            gap      = 8'($urandom_range(0, 3));
`ifdef QINJ_SCAN_BROADCAST_EN
            broadcast = ($urandom_range(0, 3) == 0);
`endif
        end
        start = 1'b0; abort = 1'b0; RST = 1'b0; broadcast = 1'b0;
        repeat (120) @(negedge CLK40);
        chk("drain_idle", 256'(busy), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qinj_scan_controller.md
QINJ_SCAN_CONTROLLER -- requirements
Module: qinj_scan_controller

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning the number of cycles QInjEn is held before the first pulse on each pixel (range 1..255).
REQ-002 SHALL have port CLK40  input  1  40 MHz clock; all logic on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  scan request, sampled every cycle.
REQ-005 SHALL have port abort  input  1  terminate scan.
REQ-006 SHALL have port startPix  input  8  first pixel index (row*16+col).
REQ-007 SHALL have port stopPix  input  8  last pixel index, inclusive.
REQ-008 SHALL have port nPulses  input  8  pulses per pixel; 0 is treated as 1.
REQ-009 SHALL have port gap  input  8  idle cycles after each pulse; 0 is treated as 1.
REQ-010 SHALL have port broadcast  input  1  all-pixel mode; present only with the macro.
REQ-011 SHALL have port QInjEn  output  256  per-pixel injection enables.
REQ-012 SHALL have port QInj  output  1  injection pulse, to the charge-injection tree input.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port curPix  output  8  pixel index currently addressed.

Function
REQ-016 SHALL implement states IDLE, SETTLE, PULSE, GAP, NEXT and DONE.
REQ-017 In IDLE, start=1 with abort=0 SHALL latch startPix, stopPix, nPulses, gap (and broadcast) and go to SETTLE; curPix=startPix.
REQ-018 Config inputs SHALL be ignored outside the latching cycle; start SHALL be ignored in every state except IDLE.
REQ-019 SETTLE SHALL last exactly SETTLE cycles, then go to PULSE.
REQ-020 PULSE SHALL last 1 cycle with QInj=1; QInj SHALL be registered and low in all other states.
REQ-021 GAP SHALL last gap cycles. If pulses issued on the pixel < nPulses, go to PULSE; otherwise go to NEXT.
REQ-022 NEXT SHALL last 1 cycle. If curPix==stopPix go to DONE; else curPix <= curPix+1 mod 256 and go to SETTLE.
REQ-023 Pixel index SHALL wrap 255->0, so stopPix<startPix scans through the wrap.
REQ-024 QInjEn SHALL be one-hot at curPix in SETTLE, PULSE and GAP, and all-zero in IDLE, NEXT and DONE.
REQ-025 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle, with QInj=0, QInjEn=0 and no done pulse.
REQ-027 Pulse counter SHALL be 8 bits and reset to 0 on entry to SETTLE.
REQ-028 Relative to a start sampled at cycle T: busy=1 and QInjEn active from T+1; first QInj at T+SETTLE+1.

Reset
REQ-029 RST=1 SHALL force IDLE in any state, including mid-scan, and clear all counters and latched config.
REQ-030 RST SHALL give QInjEn=0, QInj=0, busy=0, done=0, curPix=0.
REQ-031 A start asserted together with RST SHALL be ignored.

Configuration
REQ-032 Macro QINJ_SCAN_BROADCAST_EN defined: port broadcast exists, and a latched broadcast=1 drives all 256 QInjEn bits high wherever REQ-024 requires one-hot; the scan then runs as a single step (curPix=startPix, NEXT goes directly to DONE).
REQ-033 Macro QINJ_SCAN_BROADCAST_EN undefined: port broadcast and its logic are absent, and QInjEn is always one-hot or zero.

Verification
REQ-034 SETTLE=4, startPix=stopPix=3, nPulses=2, gap=3, start at cycle 0 -> QInj=1 at cycles 5 and 9; QInjEn[3]=1 over cycles 1-12; done=1 at cycle 14; busy=0 at cycle 15.
REQ-035 startPix=254, stopPix=1, nPulses=1 -> curPix sequence 254,255,0,1; exactly 4 QInj pulses; one done.
REQ-036 nPulses=0, gap=0 -> behaves exactly as nPulses=1, gap=1.
REQ-037 abort in the second GAP cycle -> next cycle IDLE, QInjEn=0, busy=0, no done; a following start is accepted normally.
REQ-038 RST mid-PULSE -> next cycle all outputs at reset values; start held during busy has no effect on the sequence.
REQ-039 QINJ_SCAN_BROADCAST_EN defined, broadcast=1, nPulses=3 -> QInjEn=all ones, 3 QInj pulses, one done; broadcast=0 reproduces REQ-034.
